// File: rtl/pkt_pkg.sv
// Shared types and sizes for the packet sender.
// Imported by the sender FSM and its payload buffer.
package pkt_pkg;

    localparam int MAX_PAYLOAD = 16;
    localparam int DEST_W = 2;
    localparam int BYTE_W = 8;
    localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
    localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        IDLE,
        DEST,
        SRC,
        PAYLOAD,
        WAIT_ACK
    } state_t;

endpackage

// File: rtl/pkt_tx_buf.sv
// Payload store: 16 x 8 FIFO-like buffer whose read side
// can be rewound so a packet can be replayed on retry.
module pkt_tx_buf
    import pkt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd,
    input  logic              rewind,
    input  logic              clr,
    output logic [BYTE_W-1:0] rd_data,
    output logic [CNT_W-1:0]  cnt
);

    localparam int AW = $clog2(MAX_PAYLOAD);

    logic [BYTE_W-1:0] mem [MAX_PAYLOAD];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
                cnt  <= cnt + CNT_W'(1);
            end
            if (rewind) rptr <= '0;
            else if (rd) rptr <= rptr + AW'(1);
        end
    end

    assign rd_data = mem[rptr];

endmodule

// File: rtl/pkt_sender.sv
// Packet transmitter: frames dest, src and buffered payload,
// then waits for ack and replays the packet on timeout.
module pkt_sender
    import pkt_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              start,
    input  logic [DEST_W-1:0] dest,
    input  logic [BYTE_W-1:0] src,
    input  logic              ack,
    output logic              bnd_plse,
    output logic [BYTE_W-1:0] data_in,
    output logic              busy,
    output logic [CNT_W-1:0]  buf_cnt,
    output logic              done,
    output logic              err,
    output logic [1:0]        retries
);

    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO = CW'(ACK_TIMEOUT - 1);
    localparam logic [1:0] MR = 2'(MAX_RETRY);

    state_t            state, state_d;
    logic [BYTE_W-1:0] data_q, data_d, src_q, src_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic              bnd_q, bnd_d, busy_q, busy_d;
    logic              done_q, done_d, err_q, err_d;
    logic [1:0]        ret_q, ret_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  len_q, len_d, sent_q, sent_d;
    logic              buf_wr, buf_rd, buf_rew, buf_clr;
    logic [BYTE_W-1:0] rd_data;
    logic [CNT_W-1:0]  cnt;

    pkt_tx_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr      (buf_wr),
        .wr_data (wr_data),
        .rd      (buf_rd),
        .rewind  (buf_rew),
        .clr     (buf_clr),
        .rd_data (rd_data),
        .cnt     (cnt)
    );

    // Next-state logic also computes the next registered outputs.
    always_comb begin
        state_d = state;
        data_d  = '0;
        bnd_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ret_d   = ret_q;
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        sent_d  = sent_q;
        dest_d  = dest_q;
        src_d   = src_q;
        buf_wr  = 1'b0;
        buf_rd  = 1'b0;
        buf_rew = 1'b0;
        buf_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && cnt != '0) begin
                    state_d = DEST;
                    dest_d  = dest;
                    src_d   = src;
                    len_d   = cnt;
                    busy_d  = 1'b1;
                    data_d  = BYTE_W'(dest);
                    bnd_d   = 1'b1;
                end else if (wr_en && !start && cnt < BUF_FULL) begin
                    buf_wr = 1'b1;
                end
            end
            DEST: begin
                state_d = SRC;
                data_d  = src_q;
            end
            SRC: begin
                state_d = PAYLOAD;
                data_d  = rd_data;
                bnd_d   = (len_q == CNT_W'(1));
                buf_rd  = 1'b1;
                sent_d  = CNT_W'(1);
            end
            PAYLOAD: begin
                if (sent_q == len_q) begin
                    state_d = WAIT_ACK;
                    wcnt_d  = '0;
                end else begin
                    data_d = rd_data;
                    bnd_d  = (sent_q + CNT_W'(1) == len_q);
                    buf_rd = 1'b1;
                    sent_d = sent_q + CNT_W'(1);
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    done_d  = 1'b1;
                    buf_clr = 1'b1;
                    ret_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (wcnt_q == TMO) begin
                    if (ret_q < MR) begin
                        ret_d   = ret_q + 2'd1;
                        buf_rew = 1'b1;
                        state_d = DEST;
                        data_d  = BYTE_W'(dest_q);
                        bnd_d   = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        buf_clr = 1'b1;
                        ret_d   = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            data_q <= '0;
            bnd_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ret_q  <= '0;
            wcnt_q <= '0;
            len_q  <= '0;
            sent_q <= '0;
            dest_q <= '0;
            src_q  <= '0;
        end else begin
            state  <= state_d;
            data_q <= data_d;
            bnd_q  <= bnd_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
            ret_q  <= ret_d;
            wcnt_q <= wcnt_d;
            len_q  <= len_d;
            sent_q <= sent_d;
            dest_q <= dest_d;
            src_q  <= src_d;
        end
    end

    assign data_in  = data_q;
    assign bnd_plse = bnd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign retries  = ret_q;
    assign buf_cnt  = cnt;

endmodule

// File: tb/tb_pkt_sender.sv
// Directed and random bench for pkt_sender against a queue model
// of the buffer and the expected frame on data_in.
module tb_pkt_sender;

    localparam int TMO = 8;
    localparam int MR  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic [1:0] dest = '0;
    logic [7:0] src = '0;
    logic       ack = 1'b0;
    logic       bnd_plse;
    logic [7:0] data_in;
    logic       busy;
    logic [4:0] buf_cnt;
    logic       done;
    logic       err;
    logic [1:0] retries;

    int total = 0;
    int bad = 0;
    byte unsigned mq[$];

    pkt_sender #(
        .ACK_TIMEOUT (TMO),
        .MAX_RETRY   (MR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .start    (start),
        .dest     (dest),
        .src      (src),
        .ack      (ack),
        .bnd_plse (bnd_plse),
        .data_in  (data_in),
        .busy     (busy),
        .buf_cnt  (buf_cnt),
        .done     (done),
        .err      (err),
        .retries  (retries)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, data_in, 0);
        chk({tag, "_bnd"}, bnd_plse, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cnt"}, buf_cnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ret"}, retries, 0);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_data = b;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        if (mq.size() < 16) mq.push_back(b);
        chk("buf_cnt", buf_cnt, mq.size());
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) write_byte(8'($urandom));
    endtask

    task automatic start_pkt(input logic [1:0] d, input logic [7:0] s);
        dest = d;
        src = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Frame: dest byte, src byte, payload in write order.
    task automatic send(input int ack_idx, input int try_n);
        byte unsigned q[$];
        q.push_back({6'b0, dest});
        q.push_back(src);
        foreach (mq[i]) q.push_back(mq[i]);
        chk("retries", retries, try_n);
        chk("busy", busy, 1);
        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("data%0d", i), data_in, q[i]);
            chk($sformatf("bnd%0d", i), bnd_plse,
                (i == 0 || i == q.size() - 1));
            if (i == ack_idx) ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        chk("wait_data", data_in, 0);
        chk("wait_bnd", bnd_plse, 0);
    endtask

    task automatic wait_ack(input int ack_at);
        for (int c = 0; c < TMO; c++) begin
            if (c == ack_at) ack = 1'b1;
            tick();
            ack = 1'b0;
            if (c == ack_at) break;
            if (c < TMO - 1) chk("wait_done", done, 0);
        end
    endtask

    task automatic finish_ok();
        chk("done", done, 1);
        chk("done_err", err, 0);
        chk("done_busy", busy, 0);
        chk("done_cnt", buf_cnt, 0);
        chk("done_ret", retries, 0);
        mq.delete();
        tick();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #12;
        chk_zero("rst");
        reset = 1'b1;
        tick();

        // Directed three-byte packet.
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        start_pkt(2'd2, 8'hA5);
        send(-1, 0);
        wait_ack(3);
        finish_ok();

        // Single-byte payload.
        write_byte(8'h7E);
        start_pkt(2'd0, 8'($urandom));
        send(-1, 0);
        wait_ack(0);
        finish_ok();

        // No ack: full retry sequence then err.
        load(int'($urandom_range(1, 16)));
        start_pkt(2'($urandom), 8'($urandom));
        for (int a = 0; a <= MR; a++) begin
            send(-1, a);
            wait_ack(-1);
        end
        chk("err", err, 1);
        chk("err_done", done, 0);
        chk("err_busy", busy, 0);
        chk("err_cnt", buf_cnt, 0);
        chk("err_ret", retries, 0);
        mq.delete();
        tick();
        chk("err_pulse", err, 0);

        // Overfill: 17th byte dropped.
        load(17);
        chk("full_cnt", buf_cnt, 16);
        start_pkt(2'd3, 8'($urandom));
        send(-1, 0);
        wait_ack(5);
        finish_ok();

        // start with an empty buffer does nothing.
        start_pkt(2'd1, 8'h5A);
        chk("empty_busy", busy, 0);
        chk("empty_data", data_in, 0);
        tick();
        chk("empty_bnd", bnd_plse, 0);
        chk("empty_busy2", busy, 0);

        // ack in PAYLOAD ignored, ack on timeout cycle wins.
        load(3);
        start_pkt(2'd1, 8'($urandom));
        send(3, 0);
        wait_ack(TMO - 1);
        chk("late_ret", retries, 0);
        finish_ok();

        // Reset mid-PAYLOAD.
        load(4);
        start_pkt(2'd2, 8'($urandom));
        tick();
        tick();
        chk("mid_pay_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("mid_rst");
        mq.delete();
        tick();
        chk_zero("hold_rst");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_done", done, 0);
            chk("post_err", err, 0);
            chk("post_cnt", buf_cnt, 0);
        end
        load(2);
        start_pkt(2'd3, 8'($urandom));
        send(-1, 0);
        wait_ack(1);
        finish_ok();

        // Random packets with random ack delay.
        for (int p = 0; p < 6; p++) begin
            load(int'($urandom_range(1, 16)));
            start_pkt(2'($urandom), 8'($urandom));
            send(-1, 0);
            wait_ack(int'($urandom_range(0, TMO - 1)));
            finish_ok();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pkt_sender.md
PKT_SENDER -- requirements
Module: pkt_sender

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ACK_TIMEOUT, 64, cycles waited in WAIT_ACK before a retry
  MAX_RETRY, 3, retransmissions allowed after the first attempt
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  input  1  single clock, all logic on rising edge
  reset  input  1  asynchronous, active-low reset
  wr_en  input  1  write wr_data into the payload buffer
  wr_data  input  8  payload byte
  start  input  1  request transmission of the buffered packet
  dest  input  2  destination port code; 0..3 selects router ports 1..4
  src  input  8  source address byte
  ack  input  1  packet-accepted acknowledge from the router
  bnd_plse  output  1  packet boundary pulse to the router
  data_in  output  8  byte stream into the router data_in
  busy  output  1  packet in flight
  buf_cnt  output  5  payload bytes buffered, 0..16
  done  output  1  one-cycle pulse: packet acknowledged
  err  output  1  one-cycle pulse: retries exhausted
  retries  output  2  retransmissions used on the current packet

Function
REQ-003 All outputs SHALL be registered.
REQ-004 FSM states SHALL be IDLE, DEST, SRC, PAYLOAD and WAIT_ACK.
REQ-005 wr_en SHALL store wr_data and increment buf_cnt only in IDLE with buf_cnt<16; otherwise it is ignored with no state change.
REQ-006 start SHALL be accepted only in IDLE with buf_cnt>=1; on acceptance dest, src and len=buf_cnt are latched and busy rises the next cycle.
REQ-007 start with buf_cnt=0, or while busy, SHALL be ignored.
REQ-008 wr_en and start together in IDLE: start SHALL win and the write SHALL be dropped.
REQ-009 DEST (1 cycle) SHALL drive data_in={6'b0,dest} with bnd_plse=1, first driven in the cycle after start.
REQ-010 SRC (1 cycle) SHALL drive data_in=src with bnd_plse=0.
REQ-011 PAYLOAD SHALL drive buffered bytes in write order, one per cycle, for len cycles, with bnd_plse=1 only on the last byte; for len=1 that single byte carries bnd_plse=1.
REQ-012 A packet SHALL occupy exactly len+2 consecutive cycles on data_in.
REQ-013 Outside DEST/SRC/PAYLOAD, data_in SHALL be 0 and bnd_plse SHALL be 0.
REQ-014 WAIT_ACK SHALL count cycles from 0; ack=1 while in WAIT_ACK SHALL pulse done, clear the buffer (buf_cnt=0), clear retries, drop busy and return to IDLE.
REQ-015 If the count reaches ACK_TIMEOUT-1 with ack=0 and retries<MAX_RETRY, retries SHALL increment and the FSM SHALL enter DEST, resending the identical packet from the preserved buffer.
REQ-016 If the count reaches ACK_TIMEOUT-1 with ack=0 and retries=MAX_RETRY, err SHALL pulse, the buffer SHALL clear, retries SHALL clear, busy SHALL drop and the FSM SHALL return to IDLE.
REQ-017 ack=1 on the timeout cycle SHALL be treated as success.
REQ-018 ack outside WAIT_ACK SHALL be ignored.
REQ-019 done and err SHALL never assert in the same cycle.

Reset
REQ-020 reset low SHALL immediately force IDLE with bnd_plse=0, data_in=0, busy=0, buf_cnt=0, done=0, err=0, retries=0, and clear both buffer pointers and the wait counter.
REQ-021 Reset mid-packet SHALL abandon the packet with no done or err pulse; buffer contents are discarded.

Structure
REQ-022 Shared package pkt_pkg SHALL hold the FSM state enum, MAX_PAYLOAD=16, DEST_W=2 and BYTE_W=8.
REQ-023 Payload storage SHALL be a sub-module pkt_tx_buf: 16x8 array with write pointer, read pointer, count, read-pointer rewind (retry) and clear inputs.

Verification
REQ-024 Bench SHALL cover:
  - write 0x11,0x22,0x33; start with dest=2, src=0xA5 -> data_in 02,A5,11,22,33 on cycles t+1..t+5; bnd_plse=1 at t+1 and t+5; ack 3 cycles later -> done pulse, buf_cnt=0.
  - 1-byte payload 0x7E, dest=0 -> 00,src,7E with bnd_plse on the first and last bytes only.
  - ack held 0, ACK_TIMEOUT=8 -> 3 identical resends, retries 1,2,3, then err pulse; busy low.
  - 17 writes -> buf_cnt saturates at 16; 17th byte absent from transmission; start with buf_cnt=0 -> no activity.
  - ack pulsed during PAYLOAD, then at the timeout cycle of WAIT_ACK -> first ignored, second gives done.
  - reset asserted during PAYLOAD -> all outputs 0 immediately; no done or err; next packet after reset transmits correctly.
